// File: rtl/systolic_array_ctrl.sv
// systolic_array_ctrl: sequencer for one output-stationary tile of a ROWS x COLS
// systolic array. It runs a skewed operand-feed phase (COMPUTE), then drains one
// result row per cycle (DRAIN), then pulses done.
// Optional build macro: SA_CTRL_PERF_CNT_EN enables the saturating busy-cycle
// counter on perf_busy_cycles; without it the port is tied to zero.
module systolic_array_ctrl #(
  parameter int ROWS   = 32,
  parameter int COLS   = 32,
  parameter int K_W    = 16,
  parameter int ADDR_W = 16,
  localparam int IDX_W = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [K_W-1:0]    cfg_k,
  input  logic              stall,
  output logic              busy,
  output logic              done,
  output logic              ctl_stat_bit_out,
  output logic              ctl_op2_select_out,
  output logic              ctl_out_select_out,
  output logic [ROWS-1:0]   row_vld,
  output logic [COLS-1:0]   col_vld,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              drain_vld,
  output logic [IDX_W-1:0]  drain_idx,
  output logic [31:0]       perf_busy_cycles
);

  // t must reach K+ROWS+COLS-2 for the largest K without wrapping; one extra
  // bit in the mask comparisons keeps r+K from overflowing as well.
  localparam int T_MAX = (2**K_W - 1) + ROWS + COLS - 2;
  localparam int T_W   = $clog2(T_MAX + 1);
  localparam int TX_W  = T_W + 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPUTE = 2'd1,
    S_DRAIN   = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [T_W-1:0]   r_t;
  logic [K_W-1:0]   r_k;
  logic [IDX_W-1:0] r_didx;
  logic [T_W-1:0]   w_t_last;
  logic             w_t_end;
  logic             w_d_end;
  logic [TX_W-1:0]  w_t_x;
  logic [TX_W-1:0]  w_k_x;

  // Last COMPUTE index is K+ROWS+COLS-3 (K >= 1 whenever COMPUTE is entered).
  assign w_t_last = T_W'(r_k) + T_W'(ROWS + COLS - 3);
  assign w_t_end  = (r_t == w_t_last);
  assign w_d_end  = (r_didx == IDX_W'(ROWS - 1));
  assign w_t_x    = {1'b0, r_t};
  assign w_k_x    = TX_W'(r_k);

  // State register; reset returns to IDLE immediately, even mid-tile.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state decode; stall freezes COMPUTE and DRAIN only.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (start) w_next = (cfg_k == '0) ? S_DONE : S_COMPUTE;
      S_COMPUTE: if (!stall && w_t_end) w_next = S_DRAIN;
      S_DRAIN:   if (!stall && w_d_end) w_next = S_DONE;
      S_DONE:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // Latched K, feed counter t and drain row index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_k    <= '0;
      r_t    <= '0;
      r_didx <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_k    <= cfg_k;
            r_t    <= '0;
            r_didx <= '0;
          end
        end
        S_COMPUTE: begin
          if (!stall) r_t <= w_t_end ? '0 : r_t + 1'b1;
        end
        S_DRAIN: begin
          if (!stall) r_didx <= w_d_end ? '0 : r_didx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Moore outputs: array controls, skewed valid masks and drain handshake.
  always_comb begin
    busy               = (r_state != S_IDLE);
    done               = (r_state == S_DONE);
    ctl_stat_bit_out   = (r_state == S_COMPUTE);
    ctl_op2_select_out = 1'b0;
    ctl_out_select_out = (r_state == S_DRAIN);
    rd_addr            = '0;
    drain_vld          = 1'b0;
    drain_idx          = '0;
    row_vld            = '0;
    col_vld            = '0;
    if (r_state == S_COMPUTE) begin
      rd_addr = ADDR_W'(r_t);
      if (!stall) begin
        for (int r = 0; r < ROWS; r++)
          row_vld[r] = (w_t_x >= TX_W'(r)) && (w_t_x < TX_W'(r) + w_k_x);
        for (int c = 0; c < COLS; c++)
          col_vld[c] = (w_t_x >= TX_W'(c)) && (w_t_x < TX_W'(c) + w_k_x);
      end
    end
    if (r_state == S_DRAIN) begin
      drain_idx = r_didx;
      drain_vld = !stall;
    end
  end

`ifdef SA_CTRL_PERF_CNT_EN
  logic [31:0] r_perf;

  // Saturating count of busy cycles; only reset clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      r_perf <= '0;
    else if (busy && r_perf != '1) r_perf <= r_perf + 1'b1;
  end

  assign perf_busy_cycles = r_perf;
`else
  assign perf_busy_cycles = '0;
`endif

endmodule

// File: doc/systolic_array_ctrl.md
SYSTOLIC_ARRAY_CTRL -- requirements
Module: systolic_array_ctrl

Interface
REQ-001 SHALL have parameter ROWS, default 32: array rows.
REQ-002 SHALL have parameter COLS, default 32: array columns.
REQ-003 SHALL have parameter K_W, default 16: width of reduction-length config.
REQ-004 SHALL have parameter ADDR_W, default 16: operand read-address width.
REQ-005 SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-006 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-007 SHALL have port start, input, 1: request one output-stationary tile.
REQ-008 SHALL have port cfg_k, input, K_W: reduction length K, sampled when start is accepted.
REQ-009 SHALL have port stall, input, 1: freeze sequencing while high.
REQ-010 SHALL have port busy, output, 1: high when not in IDLE.
REQ-011 SHALL have port done, output, 1: one-cycle pulse, tile complete.
REQ-012 SHALL have port ctl_stat_bit_out, output, 1: array accumulate-in-place control.
REQ-013 SHALL have port ctl_op2_select_out, output, 1: array operand-2 select.
REQ-014 SHALL have port ctl_out_select_out, output, 1: array output/drain select.
REQ-015 SHALL have port row_vld, output, ROWS: per-row left-operand valid mask, skewed.
REQ-016 SHALL have port col_vld, output, COLS: per-column top-operand valid mask, skewed.
REQ-017 SHALL have port rd_addr, output, ADDR_W: row-0/col-0 operand index t.
REQ-018 SHALL have port drain_vld, output, 1: result row present on array output bus.
REQ-019 SHALL have port drain_idx, output, clog2(ROWS): index of row being drained.
REQ-020 SHALL have port perf_busy_cycles, output, 32: busy-cycle counter (see Configuration).

Function
REQ-021 SHALL implement FSM IDLE -> COMPUTE -> DRAIN -> DONE -> IDLE.
REQ-022 SHALL accept start only in IDLE; start in any other state SHALL be ignored.
REQ-023 SHALL latch cfg_k on acceptance; accepted start with cfg_k=0 SHALL go IDLE -> DONE directly.
REQ-024 SHALL hold COMPUTE for exactly K+ROWS+COLS-2 unstalled cycles, counter t = 0 upward.
REQ-025 SHALL drive row_vld[r]=1 iff r <= t < r+K, and col_vld[c]=1 iff c <= t < c+K, in COMPUTE only.
REQ-026 SHALL drive rd_addr = t in COMPUTE, 0 elsewhere.
REQ-027 SHALL drive ctl_stat_bit_out=1 and ctl_op2_select_out=0 in COMPUTE; ctl_out_select_out=1 in DRAIN; all three 0 otherwise.
REQ-028 SHALL hold DRAIN for exactly ROWS unstalled cycles, drain_vld=1, drain_idx=0..ROWS-1 ascending.
REQ-029 SHALL hold DONE for one cycle with done=1, then return to IDLE.
REQ-030 SHALL, while stall=1 in COMPUTE or DRAIN, hold t, drain_idx and state, and force row_vld, col_vld and drain_vld to 0.
REQ-031 SHALL ignore stall in IDLE and DONE.
REQ-032 SHALL size t to hold K+ROWS+COLS-2 without wrap for K = 2^K_W-1.

Reset
REQ-033 SHALL, on rst assertion at any time including mid-tile, enter IDLE asynchronously.
REQ-034 SHALL, in reset, drive all outputs to 0 and clear t, drain_idx and the latched K.
REQ-035 SHALL ignore start during the first rising edge after rst deassertion only if rst is still high at that edge.

Configuration
REQ-036 SHALL, with macro SA_CTRL_PERF_CNT_EN defined, count every cycle with busy=1 into perf_busy_cycles, saturating at 2^32-1 and cleared only by rst.
REQ-037 SHALL, without SA_CTRL_PERF_CNT_EN, keep the port and tie perf_busy_cycles to 0, with no counter logic.

Verification (ROWS=COLS=4)
REQ-038 SHALL cover: start with cfg_k=8 at cycle 0 -> COMPUTE cycles 1-14, DRAIN 15-18, done=1 at 19, busy cycles 1-19.
REQ-039 SHALL cover: same run -> row_vld[3] high exactly at t=3..10; col_vld[0] at t=0..7; drain_idx 0,1,2,3.
REQ-040 SHALL cover: cfg_k=0 start -> done=1 at cycle 1, row_vld never asserted.
REQ-041 SHALL cover: cfg_k=8, stall high 3 cycles at t=5 -> masks 0 during stall, done slips to cycle 22.
REQ-042 SHALL cover: start re-pulsed at cycle 5 while busy -> ignored, single done at cycle 19.
REQ-043 SHALL cover: rst pulse at cycle 10 -> all outputs 0 immediately, IDLE; perf_busy_cycles=0; with SA_CTRL_PERF_CNT_EN, one full K=8 run -> perf_busy_cycles=19.
